// File: rtl/sprite_pixel_fetch_pkg.sv
// Constants shared by the sprite comparator bank and pixel fetch.
// Register field layout, sprite geometry and colour codes.
package sprite_pixel_fetch_pkg;

  localparam int SIZE_REG = 32;
  localparam int X_LSB    = 19;
  localparam int X_MSB    = 28;
  localparam int Y_LSB    = 9;
  localparam int Y_MSB    = 18;
  localparam int OFF_MSB  = 8;
  localparam int SPR_LINE = 20;
  localparam int SPR_SIZE = SPR_LINE * SPR_LINE;
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 9;
  localparam int COORD_W  = 10;
  localparam int CNT_W    = 19;

  localparam logic [COLOR_W-1:0]  BG_COLOR = 9'h000;
  localparam logic [COLOR_W-1:0]  TRANSP   = 9'h1FF;
  localparam logic [SIZE_REG-1:0] NO_HIT   = 32'h00000001;

  typedef struct packed {
    logic active;
    logic hit;
    logic hsync;
    logic vsync;
  } side_t;

  localparam side_t SIDE_RST = '{
    active: 1'b0,
    hit:    1'b0,
    hsync:  1'b1,
    vsync:  1'b1
  };

endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// Sprite memory read port.
// Address and strobe out, colour word back one cycle later.
interface sprite_pixel_fetch_if;
  import sprite_pixel_fetch_pkg::*;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [COLOR_W-1:0] mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data
  );

endinterface

// File: rtl/sprite_pixel_fetch_addr_calc.sv
// Sprite memory address for one pixel.
// Flags pixels that fall outside the sprite square.
module sprite_addr_calc
  import sprite_pixel_fetch_pkg::*;
(
  input  logic [COORD_W-1:0] spr_x_i,
  input  logic [COORD_W-1:0] spr_y_i,
  input  logic [OFF_MSB:0]   spr_off_i,
  input  logic [COORD_W-1:0] pix_x_i,
  input  logic [COORD_W-1:0] pix_y_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               in_range_o
);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  // offsets inside the sprite, then slot base plus row/column
  always_comb begin
    dx = pix_x_i - spr_x_i;
    dy = pix_y_i - spr_y_i;
    addr_o = ADDR_W'(spr_off_i) * ADDR_W'(SPR_SIZE)
           + ADDR_W'(dy) * ADDR_W'(SPR_LINE)
           + ADDR_W'(dx);
    in_range_o = (dx < COORD_W'(SPR_LINE))
              && (dy < COORD_W'(SPR_LINE));
  end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: address, memory read, colour select.
// Three-cycle pipeline with sync delayed alongside the colour.
module sprite_pixel_fetch
  import sprite_pixel_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  pixel_x,
  input  logic [COORD_W-1:0]  pixel_y,
  input  logic                active_area,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [SIZE_REG-1:0] register_read,
  sprite_pixel_fetch_if.master mem,
  output logic [COLOR_W-1:0]  color_out,
  output logic                color_valid,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [CNT_W-1:0]    frame_hits
);

  logic [ADDR_W-1:0]  addr;
  logic               in_range;
  logic               hit_s0;
  side_t              side0;

  side_t              side1_q;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_rd_q;

  side_t              side2_q;

  logic [COLOR_W-1:0] color_q, color_d;
  logic               valid_q;
  logic               hs_q;
  logic               vs_q;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   frame_hits_q, frame_hits_d;
  logic               opaque;
  logic               vs_fall;

  sprite_addr_calc u_addr (
    .spr_x_i    (register_read[X_MSB:X_LSB]),
    .spr_y_i    (register_read[Y_MSB:Y_LSB]),
    .spr_off_i  (register_read[OFF_MSB:0]),
    .pix_x_i    (pixel_x),
    .pix_y_i    (pixel_y),
    .addr_o     (addr),
    .in_range_o (in_range)
  );

  // hit decision; address is built straight from the inputs
  // so the memory read fits inside the three-cycle budget
  always_comb begin
    hit_s0 = active_area
          && (register_read != NO_HIT)
          && in_range;
    side0 = '{
      active: active_area,
      hit:    hit_s0,
      hsync:  hsync_in,
      vsync:  vsync_in
    };
    mem_addr_d = hit_s0 ? addr : mem_addr_q;
  end

  // stage 1: read request plus sideband
  always_ff @(posedge clk) begin
    if (reset) begin
      side1_q    <= SIDE_RST;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
    end else begin
      side1_q    <= side0;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= hit_s0;
    end
  end

  // stage 2: sideband waits while memory returns data
  always_ff @(posedge clk) begin
    if (reset) begin
      side2_q <= SIDE_RST;
    end else begin
      side2_q <= side1_q;
    end
  end

  // colour select and per-frame opaque pixel count
  always_comb begin
    opaque = side2_q.active
          && side2_q.hit
          && (mem.mem_data != TRANSP);
    color_d = '0;
    if (side2_q.active) begin
      color_d = opaque ? mem.mem_data : BG_COLOR;
    end
    vs_fall      = vs_q && !side2_q.vsync;
    frame_hits_d = frame_hits_q;
    hit_cnt_d    = hit_cnt_q;
    if (vs_fall) begin
      frame_hits_d = hit_cnt_q;
      hit_cnt_d    = opaque ? CNT_W'(1) : '0;
    end else if (opaque && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  // stage 3: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      color_q      <= '0;
      valid_q      <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      hit_cnt_q    <= '0;
      frame_hits_q <= '0;
    end else begin
      color_q      <= color_d;
      valid_q      <= side2_q.active;
      hs_q         <= side2_q.hsync;
      vs_q         <= side2_q.vsync;
      hit_cnt_q    <= hit_cnt_d;
      frame_hits_q <= frame_hits_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_rd   = mem_rd_q;
  assign color_out    = color_q;
  assign color_valid  = valid_q;
  assign hsync_out    = hs_q;
  assign vsync_out    = vs_q;
  assign frame_hits   = frame_hits_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch.
// Memory model answers every read one cycle after the strobe.
module tb_sprite_pixel_fetch;
  import sprite_pixel_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        active_area, hsync_in, vsync_in;
  logic [31:0] register_read;
  logic [8:0]  color_out;
  logic        color_valid, hsync_out, vsync_out;
  logic [18:0] frame_hits;
  logic [8:0]  ram_val;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] HIT_REG =
    (32'd100 << 19) | (32'd50 << 9) | 32'd2;

  sprite_pixel_fetch_if mem_bus ();

  sprite_pixel_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .active_area   (active_area),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .register_read (register_read),
    .mem           (mem_bus),
    .color_out     (color_out),
    .color_valid   (color_valid),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .frame_hits    (frame_hits)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_bus.mem_data <= mem_bus.mem_rd ? ram_val : 9'h0AA;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic act, input logic [31:0] r,
                       input int x, input int y,
                       input logic hs, input logic vs);
    active_area   = act;
    register_read = r;
    pixel_x       = 10'(x);
    pixel_y       = 10'(y);
    hsync_in      = hs;
    vsync_in      = vs;
  endtask

  task automatic idle(input int n);
    drive(1'b0, NO_HIT, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_val = 9'h0A5;
    drive(1'b0, NO_HIT, 0, 0, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (color_out !== 9'h000) begin
      errors++;
      $display("FAIL reset_color got %h want 000", color_out);
    end
    checks++;
    if (color_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", color_valid);
    end
    checks++;
    if (mem_bus.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd got %b want 0", mem_bus.mem_rd);
    end
    checks++;
    if (mem_bus.mem_addr !== 15'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d want 0", mem_bus.mem_addr);
    end
    checks++;
    if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_sync got %b%b want 11", hsync_out, vsync_out);
    end
    checks++;
    if (frame_hits !== 19'd0) begin
      errors++;
      $display("FAIL reset_hits got %0d want 0", frame_hits);
    end
    reset = 1'b0;
  endtask

  task automatic test_background();
    drive(1'b1, NO_HIT, 10, 10, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (mem_bus.mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL bg_rd[%0d] got %b want 0", k, mem_bus.mem_rd);
      end
      checks++;
      if (color_valid !== (k >= 3)) begin
        errors++;
        $display("FAIL bg_valid[%0d] got %b want %b", k, color_valid, k >= 3);
      end
      checks++;
      if (color_out !== 9'h000) begin
        errors++;
        $display("FAIL bg_color[%0d] got %h want 000", k, color_out);
      end
    end
    idle(3);
  endtask

  task automatic test_hit(input logic [8:0] data, input logic [8:0] exp);
    ram_val = data;
    drive(1'b1, HIT_REG, 105, 53, 1'b1, 1'b1);
    tick();
    checks++;
    if (mem_bus.mem_rd !== 1'b1 || mem_bus.mem_addr !== 15'd865) begin
      errors++;
      $display("FAIL hit_req got rd=%b addr=%0d want rd=1 addr=865",
               mem_bus.mem_rd, mem_bus.mem_addr);
    end
    drive(1'b0, NO_HIT, 0, 0, 1'b1, 1'b1);
    tick();
    checks++;
    if (mem_bus.mem_rd !== 1'b0 || mem_bus.mem_addr !== 15'd865) begin
      errors++;
      $display("FAIL hit_hold got rd=%b addr=%0d want rd=0 addr=865",
               mem_bus.mem_rd, mem_bus.mem_addr);
    end
    tick();
    checks++;
    if (color_out !== exp || color_valid !== 1'b1) begin
      errors++;
      $display("FAIL hit_color got %h/%b want %h/1",
               color_out, color_valid, exp);
    end
    idle(2);
  endtask

  task automatic test_guard();
    ram_val = 9'h055;
    drive(1'b1, HIT_REG, 125, 53, 1'b1, 1'b1);
    tick();
    checks++;
    if (mem_bus.mem_rd !== 1'b0 || mem_bus.mem_addr !== 15'd865) begin
      errors++;
      $display("FAIL guard_req got rd=%b addr=%0d want rd=0 addr=865",
               mem_bus.mem_rd, mem_bus.mem_addr);
    end
    drive(1'b0, NO_HIT, 0, 0, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (color_out !== BG_COLOR || color_valid !== 1'b1) begin
      errors++;
      $display("FAIL guard_color got %h/%b want 000/1",
               color_out, color_valid);
    end
    idle(2);
  endtask

  task automatic test_sync();
    logic hs_hist [0:119];
    int low_cnt;
    low_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      hs_hist[i] = !(i >= 5 && i < 101);
      drive(1'b0, NO_HIT, i, 0, hs_hist[i], 1'b1);
      tick();
      if (i >= 2) begin
        checks++;
        if (hsync_out !== hs_hist[i-2] || color_valid !== 1'b0) begin
          errors++;
          $display("FAIL sync[%0d] got hs=%b v=%b want hs=%b v=0",
                   i, hsync_out, color_valid, hs_hist[i-2]);
        end
        if (hsync_out === 1'b0) low_cnt++;
      end
    end
    checks++;
    if (low_cnt != 96) begin
      errors++;
      $display("FAIL sync_width got %0d want 96", low_cnt);
    end
  endtask

  task automatic vs_fall_check(input logic act_hit, input int exp,
                               input string name);
    if (act_hit) drive(1'b1, HIT_REG, 100, 50, 1'b1, 1'b0);
    else drive(1'b0, NO_HIT, 0, 0, 1'b1, 1'b0);
    tick();
    drive(1'b0, NO_HIT, 0, 0, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (frame_hits !== 19'(exp) || vsync_out !== 1'b0) begin
      errors++;
      $display("FAIL %s got hits=%0d vs=%b want hits=%0d vs=0",
               name, frame_hits, vsync_out, exp);
    end
    idle(3);
  endtask

  task automatic test_frame();
    vs_fall_check(1'b0, 1, "frame_prev");
    ram_val = 9'h0C3;
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, HIT_REG, 100 + (i % 20), 50 + (i / 20), 1'b1, 1'b1);
      tick();
    end
    ram_val = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, HIT_REG, 110, 55, 1'b1, 1'b1);
      tick();
    end
    ram_val = 9'h0C3;
    idle(3);
    vs_fall_check(1'b0, 25, "frame_25");
    vs_fall_check(1'b1, 0, "frame_empty");
    vs_fall_check(1'b0, 1, "frame_coincide");
  endtask

  task automatic test_reset_mid();
    ram_val = 9'h0A5;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, HIT_REG, 101 + i, 51, 1'b1, 1'b1);
      tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if (color_valid !== 1'b0 || mem_bus.mem_rd !== 1'b0
        || vsync_out !== 1'b1 || frame_hits !== 19'd0) begin
      errors++;
      $display("FAIL midreset got v=%b rd=%b vs=%b hits=%0d want 0/0/1/0",
               color_valid, mem_bus.mem_rd, vsync_out, frame_hits);
    end
    tick();
    reset = 1'b0;
    drive(1'b1, HIT_REG, 105, 53, 1'b1, 1'b1);
    tick();
    checks++;
    if (mem_bus.mem_rd !== 1'b1 || mem_bus.mem_addr !== 15'd865) begin
      errors++;
      $display("FAIL resume_req got rd=%b addr=%0d want rd=1 addr=865",
               mem_bus.mem_rd, mem_bus.mem_addr);
    end
    drive(1'b0, NO_HIT, 0, 0, 1'b1, 1'b1);
    tick();
    checks++;
    if (color_valid !== 1'b0) begin
      errors++;
      $display("FAIL resume_early got v=%b want 0", color_valid);
    end
    tick();
    checks++;
    if (color_out !== 9'h0A5 || color_valid !== 1'b1) begin
      errors++;
      $display("FAIL resume_color got %h/%b want 0a5/1",
               color_out, color_valid);
    end
    idle(2);
    vs_fall_check(1'b0, 1, "resume_count");
  endtask

  initial begin
    test_reset();
    test_background();
    test_hit(9'h0A5, 9'h0A5);
    test_hit(9'h1FF, BG_COLOR);
    test_guard();
    test_sync();
    test_frame();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
